boid_fb_renderer: RTL and testbench



---
 rtl/boid_fb_renderer.sv | 171 +++++++++++++++++
 tb/tb_boid_fb_renderer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/boid_fb_renderer.sv
// boid_fb_renderer
//   Reads every boid slot once per frame from the boid state memory and
//   refreshes its pixel in the framebuffer. The old pixel is erased to
//   BG_COLOR and the new one is drawn in BOID_COLOR.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   start             frame trigger, accepted only while idle
//   busy / done       sweep in progress / one-cycle completion pulse
//   rd_en, rd_idx     one-cycle read request and slot index to boid memory
//   rd_valid, x_rd,   read response carrying signed 16.16 x/y
//   y_rd
//   fb_addr, fb_data, framebuffer write. A write is accepted on any cycle
//   fb_we, fb_ready   where fb_we && fb_ready.
module boid_fb_renderer #(
  parameter int N_BOIDS   = 2,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int FB_ADDR_W = 19,
  parameter int COLOR_W   = 8,
  parameter logic [COLOR_W-1:0] BOID_COLOR = 8'hFF,
  parameter logic [COLOR_W-1:0] BG_COLOR   = 8'h00,
  localparam int IDX_W = $clog2(N_BOIDS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [IDX_W-1:0]     rd_idx,
  input  logic                 rd_valid,
  input  logic [31:0]          x_rd,
  input  logic [31:0]          y_rd,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready
);

  // The per-slot tables are sized to the full index range so that any
  // rd_idx value can index them directly. Only N_BOIDS entries are used.
  localparam int SLOTS = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, READ, WAIT, ERASE, DRAW, NEXT, DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [9:0]       px_q;
  logic [8:0]       py_q;
  logic             vis_q;
  logic             erase_q;
  logic [9:0]       prev_px_q [SLOTS];
  logic [8:0]       prev_py_q [SLOTS];
  logic [SLOTS-1:0] prev_valid_q;

  // Integer parts of the read response. Any negative value has bit 15 set,
  // so it is off-screen. It never wraps onto the screen.
  logic [15:0]          xi, yi;
  logic                 vis_d, erase_d;
  logic [FB_ADDR_W-1:0] prev_addr, new_addr;

  assign xi = x_rd[31:16];
  assign yi = y_rd[31:16];

  always_comb begin
    vis_d = !xi[15] && (xi[14:0] < 15'(SCREEN_W)) &&
            !yi[15] && (yi[14:0] < 15'(SCREEN_H));
    // Skip the erase when the boid is redrawn on the same pixel.
    // The draw then overwrites it with the same colour anyway.
    erase_d = prev_valid_q[idx_q] &&
              !(vis_d && (xi[9:0] == prev_px_q[idx_q]) && (yi[8:0] == prev_py_q[idx_q]));
  end

  assign prev_addr = FB_ADDR_W'(prev_py_q[idx_q]) * FB_ADDR_W'(SCREEN_W)
                   + FB_ADDR_W'(prev_px_q[idx_q]);
  assign new_addr  = FB_ADDR_W'(py_q) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(px_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      vis_q        <= 1'b0;
      erase_q      <= 1'b0;
      prev_valid_q <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        prev_px_q[s] <= '0;
        prev_py_q[s] <= '0;
      end
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_idx  <= '0;
      fb_addr <= '0;
      fb_data <= '0;
      fb_we   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          idx_q   <= '0;
          rd_idx  <= '0;
          rd_en   <= 1'b1;
          busy    <= 1'b1;
          state_q <= READ;
        end
        READ: begin
          rd_en   <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (rd_valid) begin
          px_q    <= xi[9:0];
          py_q    <= yi[8:0];
          vis_q   <= vis_d;
          erase_q <= erase_d;
          state_q <= ERASE;
        end
        // ERASE and DRAW both raise fb_we on the first cycle they are in.
        // They hold it until the write is accepted and drop it on the next
        // cycle, so there is always a gap cycle between two writes.
        ERASE: begin
          if (!erase_q) begin
            state_q <= DRAW;
          end else if (!fb_we) begin
            fb_we   <= 1'b1;
            fb_addr <= prev_addr;
            fb_data <= BG_COLOR;
          end else if (fb_ready) begin
            fb_we   <= 1'b0;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (!vis_q) begin
            prev_valid_q[idx_q] <= 1'b0;
            state_q             <= NEXT;
          end else if (!fb_we) begin
            fb_we   <= 1'b1;
            fb_addr <= new_addr;
            fb_data <= BOID_COLOR;
          end else if (fb_ready) begin
            fb_we               <= 1'b0;
            prev_px_q[idx_q]    <= px_q;
            prev_py_q[idx_q]    <= py_q;
            prev_valid_q[idx_q] <= 1'b1;
            state_q             <= NEXT;
          end
        end
        NEXT: begin
          if (idx_q == IDX_W'(N_BOIDS - 1)) begin
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            rd_idx  <= idx_q + 1'b1;
            rd_en   <= 1'b1;
            state_q <= READ;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boid_fb_renderer.sv
module tb_boid_fb_renderer;

  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, rd_en, fb_we;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid = 1'b0;
  logic [31:0]       x_rd = '0, y_rd = '0;
  logic [18:0]       fb_addr;
  logic [7:0]        fb_data;
  logic              fb_ready = 1'b1;

  boid_fb_renderer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .x_rd(x_rd), .y_rd(y_rd),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [18:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  int comps = 0, fails = 0;
  int done_cnt = 0, exp_done = 0;
  logic [31:0] mem_x [4];
  logic [31:0] mem_y [4];
  logic mem_block = 1'b0;
  logic stall_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Boid memory: answers one cycle after rd_en unless blocked.
  always begin
    logic req;
    logic [IDX_W-1:0] ridx;
    @(negedge clk);
    req  = rd_en && !reset;
    ridx = rd_idx;
    @(posedge clk);
    #1;
    if (req && !mem_block) begin
      rd_valid = 1'b1;
      x_rd     = mem_x[ridx];
      y_rd     = mem_y[ridx];
    end else begin
      rd_valid = 1'b0;
    end
  end

  // Write monitor: every accepted write must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && fb_we && fb_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {13'd0, fb_addr}, 32'hFFFFFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {13'd0, fb_addr}, {13'd0, e.addr});
        chk("wr_data", {24'd0, fb_data}, {24'd0, e.data});
      end
    end
  end

  // Done monitor.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      chk("busy_with_done", {31'd0, busy}, 32'd1);
    end
  end

  // Backpressure: holds fb_ready low for the first 5 cycles of the first write.
  always begin
    @(negedge clk);
    if (stall_req) begin
      logic [18:0] s_addr;
      logic [7:0]  s_data;
      int n;
      fb_ready = 1'b0;
      n = 0;
      while (!fb_we && n < 200) begin @(negedge clk); n++; end
      chk("stall_we_seen", {31'd0, fb_we}, 32'd1);
      s_addr = fb_addr;
      s_data = fb_data;
      chk("stall_first_addr", {13'd0, s_addr}, 32'd67305);
      for (int k = 1; k < 5; k++) begin
        @(negedge clk);
        chk("stall_we", {31'd0, fb_we}, 32'd1);
        chk("stall_addr", {13'd0, fb_addr}, {13'd0, s_addr});
        chk("stall_data", {24'd0, fb_data}, {24'd0, s_data});
      end
      @(posedge clk);
      #1 fb_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("we_drop_after_accept", {31'd0, fb_we}, 32'd0);
      wait (!stall_req);
    end
  end

  task automatic push(input logic [18:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic sweep(input string name, input logic [31:0] x0, y0, x1, y1,
                       input bit extra_start);
    int n, d0;
    mem_x[0] = x0; mem_y[0] = y0;
    mem_x[1] = x1; mem_y[1] = y1;
    d0 = done_cnt;
    exp_done++;
    pulse_start();
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 500) begin @(negedge clk); n++; end
    chk({name, "_done_timeout"}, {31'd0, (done_cnt == d0)}, 32'd0);
    repeat (10) @(negedge clk);
    chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({name, "_done_count"}, done_cnt, exp_done);
    chk({name, "_writes_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    mem_x[2] = '0; mem_y[2] = '0; mem_x[3] = '0; mem_y[3] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    {31'd0, busy},  32'd0);
    chk("rst_done",    {31'd0, done},  32'd0);
    chk("rst_rd_en",   {31'd0, rd_en}, 32'd0);
    chk("rst_fb_we",   {31'd0, fb_we}, 32'd0);
    chk("rst_rd_idx",  {30'd0, rd_idx}, 32'd0);
    chk("rst_fb_addr", {13'd0, fb_addr}, 32'd0);
    chk("rst_fb_data", {24'd0, fb_data}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // First sweep, with the first write held off by fb_ready for 5 cycles.
    stall_req = 1'b1;
    repeat (3) @(posedge clk);
    push(19'd67305, 8'hFF); push(19'd73715, 8'hFF);
    sweep("s1", 105 << 16, 105 << 16, 115 << 16, 115 << 16, 1'b0);
    stall_req = 1'b0;

    // Slot0 moves one pixel right; a start during the sweep is ignored.
    push(19'd67305, 8'h00); push(19'd67306, 8'hFF); push(19'd73715, 8'hFF);
    sweep("s2", 106 << 16, 105 << 16, 115 << 16, 115 << 16, 1'b1);

    // x = -1: erase only. Then x = 640: nothing at all for slot0.
    push(19'd67306, 8'h00); push(19'd73715, 8'hFF);
    sweep("s3", 32'hFFFF0000, 105 << 16, 115 << 16, 115 << 16, 1'b0);
    push(19'd73715, 8'hFF);
    sweep("s4", 640 << 16, 105 << 16, 115 << 16, 115 << 16, 1'b0);

    // Bottom-right pixel, with fractions truncated; slot1 goes to y = 480.
    push(19'd307199, 8'hFF); push(19'd73715, 8'h00);
    sweep("s5", (639 << 16) | 32'hFFFF, (479 << 16) | 32'h8000,
          115 << 16, 480 << 16, 1'b0);

    // Reset while waiting on memory: the sweep is abandoned with no done.
    mem_block = 1'b1;
    pulse_start();
    repeat (4) @(negedge clk);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy",  {31'd0, busy},  32'd0);
    chk("arst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("arst_fb_we", {31'd0, fb_we}, 32'd0);
    chk("arst_done",  {31'd0, done},  32'd0);
    @(posedge clk); #1 reset = 1'b0;
    mem_block = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_done", done_cnt, exp_done);

    // All prev_valid bits were cleared, so this sweep only draws.
    push(19'd67305, 8'hFF); push(19'd73715, 8'hFF);
    sweep("s6", 105 << 16, 105 << 16, 115 << 16, 115 << 16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
    $finish;
  end

endmodule
